// File: rtl/video_timing_generator_pkg.sv
// Shared 640x480@60 VGA timing constants and the small types used by the raster generator.
package video_timing_generator_pkg;

    localparam int VGA_H_ACTIVE = 640;
    localparam int VGA_H_FRONT  = 16;
    localparam int VGA_H_SYNC   = 96;
    localparam int VGA_H_BACK   = 48;
    localparam int VGA_H_TOTAL  = VGA_H_ACTIVE + VGA_H_FRONT + VGA_H_SYNC + VGA_H_BACK;
    localparam int VGA_HS_START = VGA_H_ACTIVE + VGA_H_FRONT;
    localparam int VGA_HS_END   = VGA_HS_START + VGA_H_SYNC - 1;

    localparam int VGA_V_ACTIVE = 480;
    localparam int VGA_V_FRONT  = 10;
    localparam int VGA_V_SYNC   = 2;
    localparam int VGA_V_BACK   = 33;
    localparam int VGA_V_TOTAL  = VGA_V_ACTIVE + VGA_V_FRONT + VGA_V_SYNC + VGA_V_BACK;
    localparam int VGA_VS_START = VGA_V_ACTIVE + VGA_V_FRONT;
    localparam int VGA_VS_END   = VGA_VS_START + VGA_V_SYNC - 1;

    localparam int VGA_FB_WIDTH    = 320;
    localparam int VGA_MEM_LATENCY = 1;
    localparam int VGA_SYNC_DELAY  = 2;

    localparam int COORD_W = 10;
    localparam int ADDR_W  = 17;

    typedef logic [COORD_W-1:0] coord_t;

    typedef struct packed {
        coord_t y;
        coord_t x;
    } position_t;

    // Sync bits are carried as "asserted" flags so an all-zero pipeline means idle sync lines.
    typedef struct packed {
        logic active;
        logic hsync_on;
        logic vsync_on;
    } sync_bits_t;

endpackage

// File: rtl/video_timing_generator_delay_line.sv
// Enable-gated shift register used to align position and sync with the frame-buffer read pipeline.
module video_delay_line #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             enable,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] stage [DEPTH];

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage[i] <= '0;
            end
        end else if (enable) begin
            stage[0] <= d;
            for (int i = 1; i < DEPTH; i++) begin
                stage[i] <= stage[i-1];
            end
        end
    end

    assign q = stage[DEPTH-1];

endmodule

// File: rtl/video_timing_generator.sv
// VGA raster timing: h/v counters, frame-buffer read port, aligned position, delayed sync/blank and
// tear-free frame select. Everything advances only on cycles where pixel_enable is high.
module video_timing_generator
    import video_timing_generator_pkg::*;
#(
    parameter int H_ACTIVE    = VGA_H_ACTIVE,
    parameter int H_FRONT     = VGA_H_FRONT,
    parameter int H_SYNC      = VGA_H_SYNC,
    parameter int H_BACK      = VGA_H_BACK,
    parameter int V_ACTIVE    = VGA_V_ACTIVE,
    parameter int V_FRONT     = VGA_V_FRONT,
    parameter int V_SYNC      = VGA_V_SYNC,
    parameter int V_BACK      = VGA_V_BACK,
    parameter int FB_WIDTH    = VGA_FB_WIDTH,
    parameter int MEM_LATENCY = VGA_MEM_LATENCY,
    parameter int SYNC_DELAY  = VGA_SYNC_DELAY
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              pixel_enable,
    input  logic              frame_select_request,
    output logic              frame_select_memory,
    output logic              fb_read_enable,
    output logic [ADDR_W-1:0] fb_read_address,
    output coord_t            pixel_x_pos,
    output coord_t            pixel_y_pos,
    output logic              vga_hsync,
    output logic              vga_vsync,
    output logic              vga_blank_n,
    output logic              frame_start,
    output logic              vblank
);

    localparam coord_t H_ACT    = coord_t'(H_ACTIVE);
    localparam coord_t H_LAST   = coord_t'(H_ACTIVE + H_FRONT + H_SYNC + H_BACK - 1);
    localparam coord_t HS_FIRST = coord_t'(H_ACTIVE + H_FRONT);
    localparam coord_t HS_LAST  = coord_t'(H_ACTIVE + H_FRONT + H_SYNC - 1);
    localparam coord_t V_ACT    = coord_t'(V_ACTIVE);
    localparam coord_t V_LAST   = coord_t'(V_ACTIVE + V_FRONT + V_SYNC + V_BACK - 1);
    localparam coord_t VS_FIRST = coord_t'(V_ACTIVE + V_FRONT);
    localparam coord_t VS_LAST  = coord_t'(V_ACTIVE + V_FRONT + V_SYNC - 1);

    coord_t            h_count;
    coord_t            v_count;
    logic              h_wrap;
    logic              v_wrap;
    logic              active;
    sync_bits_t        sync_now;
    sync_bits_t        sync_out;
    position_t         pos_now;
    position_t         pos_out;
    logic [ADDR_W-1:0] row_base;
    logic [ADDR_W-1:0] address_now;

    assign h_wrap = (h_count == H_LAST);
    assign v_wrap = (v_count == V_LAST);
    assign active = (h_count < H_ACT) && (v_count < V_ACT);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            h_count <= '0;
            v_count <= '0;
        end else if (pixel_enable) begin
            if (h_wrap) begin
                h_count <= '0;
                v_count <= v_wrap ? '0 : v_count + coord_t'(1);
            end else begin
                h_count <= h_count + coord_t'(1);
            end
        end
    end

    always_comb begin
        sync_now          = '0;
        sync_now.active   = active;
        sync_now.hsync_on = (h_count >= HS_FIRST) && (h_count <= HS_LAST);
        sync_now.vsync_on = (v_count >= VS_FIRST) && (v_count <= VS_LAST);
    end

    // (v/2)*FB_WIDTH as a sum of shifted rows, one adder per set bit of the constant width.
    always_comb begin
        row_base = '0;
        for (int b = 0; b < ADDR_W; b++) begin
            if (FB_WIDTH[b]) begin
                row_base = row_base + (ADDR_W'(v_count[COORD_W-1:1]) << b);
            end
        end
        address_now = row_base + ADDR_W'(h_count[COORD_W-1:1]);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            fb_read_enable  <= 1'b0;
            fb_read_address <= '0;
        end else if (pixel_enable) begin
            fb_read_enable  <= active;
            fb_read_address <= active ? address_now : '0;
        end
    end

    // Only sampled at the first blanking line so a CPU flip never lands mid-scan.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            frame_select_memory <= 1'b0;
        end else if (pixel_enable && (h_count == '0) && (v_count == V_ACT)) begin
            frame_select_memory <= frame_select_request;
        end
    end

    assign pos_now = '{y: v_count, x: h_count};

    video_delay_line #(
        .WIDTH ($bits(position_t)),
        .DEPTH (MEM_LATENCY)
    ) u_position_delay (
        .clock  (clock),
        .reset  (reset),
        .enable (pixel_enable),
        .d      (pos_now),
        .q      (pos_out)
    );

    video_delay_line #(
        .WIDTH ($bits(sync_bits_t)),
        .DEPTH (SYNC_DELAY)
    ) u_sync_delay (
        .clock  (clock),
        .reset  (reset),
        .enable (pixel_enable),
        .d      (sync_now),
        .q      (sync_out)
    );

    assign pixel_x_pos = pos_out.x;
    assign pixel_y_pos = pos_out.y;
    assign vga_blank_n = sync_out.active;
    assign vga_hsync   = ~sync_out.hsync_on;
    assign vga_vsync   = ~sync_out.vsync_on;
    assign frame_start = pixel_enable && h_wrap && v_wrap;
    assign vblank      = (v_count >= V_ACT);

endmodule

// File: tb/tb_video_timing_generator.sv
// Bench for video_timing_generator: a full-size VGA instance and a shrunken-timing instance share
// stimulus and are checked every cycle against a strobe-count arithmetic model.
module tb_video_timing_generator;

    typedef struct packed {
        int ha; int hf; int hs; int hb;
        int va; int vf; int vs; int vb;
        int fbw; int ml; int sd;
    } cfg_t;

    typedef struct packed {
        logic        fsm;
        logic        en;
        logic [16:0] addr;
        logic [9:0]  px;
        logic [9:0]  py;
        logic        hs;
        logic        vs;
        logic        bn;
        logic        fst;
        logic        vb;
    } obs_t;

    localparam cfg_t FULL  = '{ha: 640, hf: 16, hs: 96, hb: 48, va: 480, vf: 10, vs: 2, vb: 33,
                               fbw: 320, ml: 1, sd: 2};
    localparam cfg_t SMALL = '{ha: 16, hf: 4, hs: 6, hb: 4, va: 12, vf: 2, vs: 2, vb: 3,
                               fbw: 8, ml: 3, sd: 4};
    localparam obs_t RESET_OBS = '{fsm: 1'b0, en: 1'b0, addr: 17'd0, px: 10'd0, py: 10'd0,
                                   hs: 1'b1, vs: 1'b1, bn: 1'b0, fst: 1'b0, vb: 1'b0};

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic pixel_enable = 1'b0;
    logic frame_select_request = 1'b0;

    logic        fsm_f, en_f, hs_f, vs_f, bn_f, fst_f, vb_f;
    logic [16:0] addr_f;
    logic [9:0]  px_f, py_f;
    logic        fsm_s, en_s, hs_s, vs_s, bn_s, fst_s, vb_s;
    logic [16:0] addr_s;
    logic [9:0]  px_s, py_s;
    obs_t        obs_full, obs_small;

    int checks = 0;
    int errors = 0;
    int n = 0;
    logic fs_full = 1'b0;
    logic fs_small = 1'b0;

    // ---------------- clock / DUTs ----------------
    always #5 clk = ~clk;

    video_timing_generator u_full (
        .clock                (clk),
        .reset                (rst_n),
        .pixel_enable         (pixel_enable),
        .frame_select_request (frame_select_request),
        .frame_select_memory  (fsm_f),
        .fb_read_enable       (en_f),
        .fb_read_address      (addr_f),
        .pixel_x_pos          (px_f),
        .pixel_y_pos          (py_f),
        .vga_hsync            (hs_f),
        .vga_vsync            (vs_f),
        .vga_blank_n          (bn_f),
        .frame_start          (fst_f),
        .vblank               (vb_f)
    );

    video_timing_generator #(
        .H_ACTIVE (16), .H_FRONT (4), .H_SYNC (6), .H_BACK (4),
        .V_ACTIVE (12), .V_FRONT (2), .V_SYNC (2), .V_BACK (3),
        .FB_WIDTH (8), .MEM_LATENCY (3), .SYNC_DELAY (4)
    ) u_small (
        .clock                (clk),
        .reset                (rst_n),
        .pixel_enable         (pixel_enable),
        .frame_select_request (frame_select_request),
        .frame_select_memory  (fsm_s),
        .fb_read_enable       (en_s),
        .fb_read_address      (addr_s),
        .pixel_x_pos          (px_s),
        .pixel_y_pos          (py_s),
        .vga_hsync            (hs_s),
        .vga_vsync            (vs_s),
        .vga_blank_n          (bn_s),
        .frame_start          (fst_s),
        .vblank               (vb_s)
    );

    assign obs_full  = {fsm_f, en_f, addr_f, px_f, py_f, hs_f, vs_f, bn_f, fst_f, vb_f};
    assign obs_small = {fsm_s, en_s, addr_s, px_s, py_s, hs_s, vs_s, bn_s, fst_s, vb_s};

    // ---------------- reference model ----------------
    function automatic int htot(cfg_t c);
        return c.ha + c.hf + c.hs + c.hb;
    endfunction

    function automatic int vtot(cfg_t c);
        return c.va + c.vf + c.vs + c.vb;
    endfunction

    function automatic int hpos(cfg_t c, int k);
        return k % htot(c);
    endfunction

    function automatic int vpos(cfg_t c, int k);
        return (k / htot(c)) % vtot(c);
    endfunction

    // Outputs after n strobes since reset; pe is the strobe level presented this cycle.
    function automatic obs_t model_out(cfg_t c, int k, logic pe, logic fs);
        obs_t e;
        int   h;
        int   v;
        e = RESET_OBS;
        e.fsm = fs;
        if (k >= 1) begin
            h = hpos(c, k - 1);
            v = vpos(c, k - 1);
            if (h < c.ha && v < c.va) begin
                e.en   = 1'b1;
                e.addr = 17'((v / 2) * c.fbw + h / 2);
            end
        end
        if (k >= c.ml) begin
            e.px = 10'(hpos(c, k - c.ml));
            e.py = 10'(vpos(c, k - c.ml));
        end
        if (k >= c.sd) begin
            h = hpos(c, k - c.sd);
            v = vpos(c, k - c.sd);
            e.bn = (h < c.ha) && (v < c.va);
            e.hs = !((h >= c.ha + c.hf) && (h < c.ha + c.hf + c.hs));
            e.vs = !((v >= c.va + c.vf) && (v < c.va + c.vf + c.vs));
        end
        h = hpos(c, k);
        v = vpos(c, k);
        e.vb  = (v >= c.va);
        e.fst = pe && (h == htot(c) - 1) && (v == vtot(c) - 1);
        return e;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            n = 0;
            fs_full = 1'b0;
            fs_small = 1'b0;
        end else if (pixel_enable) begin
            if (hpos(FULL, n) == 0 && vpos(FULL, n) == FULL.va) fs_full = frame_select_request;
            if (hpos(SMALL, n) == 0 && vpos(SMALL, n) == SMALL.va) fs_small = frame_select_request;
            n = n + 1;
        end
    end

    // ---------------- scoreboard ----------------
    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s (n=%0d): got %0d expected %0d", name, n, act, exp);
        end
    endtask

    task automatic cmp_obs(input string name, input obs_t a, input obs_t e);
        checks++;
        if (a != e) begin
            errors++;
            $display("FAIL %s n=%0d: got fsm=%0d en=%0d addr=%0d x=%0d y=%0d hs=%0d vs=%0d bn=%0d fst=%0d vb=%0d expected fsm=%0d en=%0d addr=%0d x=%0d y=%0d hs=%0d vs=%0d bn=%0d fst=%0d vb=%0d",
                     name, n, a.fsm, a.en, a.addr, a.px, a.py, a.hs, a.vs, a.bn, a.fst, a.vb,
                     e.fsm, e.en, e.addr, e.px, e.py, e.hs, e.vs, e.bn, e.fst, e.vb);
        end
    endtask

    always @(negedge clk) begin
        cmp_obs("full_outputs", obs_full, model_out(FULL, n, pixel_enable, fs_full));
        cmp_obs("small_outputs", obs_small, model_out(SMALL, n, pixel_enable, fs_small));
    end

    int   last_fall = -1;
    logic prev_hs = 1'b1;
    always @(negedge clk) begin
        if (!rst_n) begin
            last_fall = -1;
            prev_hs = 1'b1;
        end else begin
            if (prev_hs && !hs_f) begin
                if (last_fall >= 0) chk("line_length_strobes", n - last_fall, 800);
                last_fall = n;
            end
            prev_hs = hs_f;
        end
    end

    task automatic check_reset(input string tag);
        cmp_obs({tag, "_full"}, obs_full, RESET_OBS);
        cmp_obs({tag, "_small"}, obs_small, RESET_OBS);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        obs_t m;
        m = model_out(FULL, 5 * 800 + 3 + 1, 1'b0, 1'b0);
        chk("model_addr_h3_v5", int'(m.addr), 641);
        m = model_out(FULL, 479 * 800 + 639 + 1, 1'b0, 1'b0);
        chk("model_addr_max", int'(m.addr), 76799);
        m = model_out(FULL, 641, 1'b0, 1'b0);
        chk("model_en_h640", int'(m.en), 0);

        pixel_enable = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset("reset_initial");
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Directed run with pixel_enable held high.
        for (int i = 0; i < 4012; i++) begin
            @(negedge clk);
            case (n)
                1:    begin chk("en_first", en_f, 1); chk("addr_first", addr_f, 0); chk("blank_n_n1", bn_f, 0); end
                2:    chk("blank_n_n2", bn_f, 1);
                3:    chk("addr_h2", addr_f, 1);
                359:  chk("small_vblank_before", vb_s, 0);
                360:  begin chk("small_fsm_hold", fsm_s, 0); chk("small_vblank_start", vb_s, 1); end
                361:  chk("small_fsm_latch", fsm_s, 1);
                569:  chk("small_frame_start", fst_s, 1);
                570:  chk("small_frame_start_end", fst_s, 0);
                640:  begin chk("en_h639", en_f, 1); chk("addr_h639", addr_f, 319); end
                641:  begin chk("en_h640", en_f, 0); chk("addr_h640", addr_f, 0); end
                657:  chk("hsync_before_fall", hs_f, 1);
                658:  chk("hsync_fall", hs_f, 0);
                753:  chk("hsync_last_low", hs_f, 0);
                754:  chk("hsync_rise", hs_f, 1);
                930:  chk("small_fsm_before_edge", fsm_s, 1);
                931:  chk("small_fsm_edge_capture", fsm_s, 0);
                4004: begin chk("addr_h3_v5", addr_f, 641); chk("en_h3_v5", en_f, 1); end
                default: ;
            endcase
            @(posedge clk);
            #1;
            frame_select_request = (n >= 300 && n < 930);
        end

        // Stall: one strobe every four clocks.
        for (int i = 0; i < 3300; i++) begin
            @(posedge clk);
            #1;
            pixel_enable = (i % 4 == 0);
            if ($urandom_range(0, 15) == 0) frame_select_request = ~frame_select_request;
        end

        // Random strobes and frequent frame-select flips.
        for (int i = 0; i < 6000; i++) begin
            @(posedge clk);
            #1;
            pixel_enable = ($urandom_range(0, 99) < 70);
            if ($urandom_range(0, 7) == 0) frame_select_request = ~frame_select_request;
        end

        // Asynchronous reset between clock edges.
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset("reset_async");
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        pixel_enable = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            case (n)
                1: begin chk("restart_x", px_f, 0); chk("restart_y", py_f, 0); chk("restart_en", en_f, 1); end
                2: chk("restart_x_n2", px_f, 1);
                3: chk("restart_addr_n3", addr_f, 1);
                default: ;
            endcase
        end

        for (int i = 0; i < 1500; i++) begin
            @(posedge clk);
            #1;
            pixel_enable = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 5) == 0) frame_select_request = ~frame_select_request;
        end

        @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
